// File: rtl/neopixel_rx_if.sv
// Signal bundle between the WS2812 decoder and its consumer.
// pixel_valid, frame_end and bit_err are single-cycle strobes with no ready: the consumer must take pixel_data on the cycle pixel_valid is high.
interface neopixel_rx_if;
  logic        din;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        frame_end;
  logic        bit_err;
  logic        dout;
  logic [7:0]  pixel_count;
  logic [1:0]  state_dbg;

  modport master (
    input  din,
    output pixel_data, pixel_valid, frame_end, bit_err, dout, pixel_count, state_dbg
  );

  modport slave (
    output din,
    input  pixel_data, pixel_valid, frame_end, bit_err, dout, pixel_count, state_dbg
  );
endinterface

// File: rtl/neopixel_rx.sv
// WS2812 receiver: decodes the first 24-bit GRB word after each latch gap,
// then forwards the remaining bit stream to the next pixel on dout.
module neopixel_rx #(
  parameter int T_MIN    = 5,
  parameter int T_THRESH = 30,
  parameter int T_MAX    = 60,
  parameter int T_LATCH  = 2500
) (
  input  logic CLOCK_50,
  input  logic reset,
  neopixel_rx_if.master bus
);

  typedef enum logic [1:0] {WAIT_LATCH, CAPTURE, PASS} state_t;

  localparam logic [6:0]  HI_MIN    = 7'(T_MIN);
  localparam logic [6:0]  HI_THRESH = 7'(T_THRESH);
  localparam logic [6:0]  HI_MAX    = 7'(T_MAX);
  localparam logic [11:0] LO_LATCH  = 12'(T_LATCH);
  localparam logic [11:0] LO_HIT    = 12'(T_LATCH - 1);

  state_t      state_q, state_d;
  logic        din_s1, ds, ds_d;
  logic        rise, fall, latch_hit, bit_val, pulse_bad;
  logic [6:0]  hi_cnt;
  logic [11:0] lo_cnt;
  logic [23:0] shreg, shreg_d, word_d;
  logic [4:0]  bit_cnt, bit_cnt_d;
  logic        pv_d, fe_d, be_d;
  logic [23:0] pixel_data_q;
  logic        pixel_valid_q, frame_end_q, bit_err_q, dout_q;
  logic [7:0]  pixel_count_q;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      din_s1 <= 1'b0;
      ds     <= 1'b0;
      ds_d   <= 1'b0;
    end else begin
      din_s1 <= bus.din;
      ds     <= din_s1;
      ds_d   <= ds;
    end
  end

  assign rise = ds & ~ds_d;
  assign fall = ~ds & ds_d;

  // Rising edge restarts both counters; the high counter counts that first cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      hi_cnt <= '0;
      lo_cnt <= '0;
    end else begin
      if (rise)                          hi_cnt <= 7'd1;
      else if (ds && hi_cnt != 7'd127)   hi_cnt <= hi_cnt + 7'd1;
      if (rise)                          lo_cnt <= '0;
      else if (!ds && lo_cnt != LO_LATCH) lo_cnt <= lo_cnt + 12'd1;
    end
  end

  // Fires only on the cycle the low count arrives at T_LATCH, so a held-low line latches once.
  assign latch_hit = ~ds && (lo_cnt == LO_HIT);
  assign bit_val   = hi_cnt > HI_THRESH;
  assign pulse_bad = (hi_cnt < HI_MIN) || (hi_cnt > HI_MAX);
  assign word_d    = {shreg[22:0], bit_val};

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_q <= WAIT_LATCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg;
    bit_cnt_d = bit_cnt;
    pv_d      = 1'b0;
    fe_d      = 1'b0;
    be_d      = 1'b0;
    case (state_q)
      WAIT_LATCH: begin
        if (latch_hit) begin
          state_d   = CAPTURE;
          shreg_d   = '0;
          bit_cnt_d = '0;
          fe_d      = 1'b1;
        end
      end
      CAPTURE: begin
        if (latch_hit) begin
          shreg_d   = '0;
          bit_cnt_d = '0;
          fe_d      = 1'b1;
        end else if (fall) begin
          if (pulse_bad) begin
            state_d   = WAIT_LATCH;
            shreg_d   = '0;
            bit_cnt_d = '0;
            be_d      = 1'b1;
          end else if (bit_cnt == 5'd23) begin
            state_d   = PASS;
            shreg_d   = '0;
            bit_cnt_d = '0;
            pv_d      = 1'b1;
          end else begin
            shreg_d   = word_d;
            bit_cnt_d = bit_cnt + 5'd1;
          end
        end
      end
      PASS: begin
        if (latch_hit) begin
          state_d   = CAPTURE;
          shreg_d   = '0;
          bit_cnt_d = '0;
          fe_d      = 1'b1;
        end
      end
      default: state_d = WAIT_LATCH;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      shreg         <= '0;
      bit_cnt       <= '0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      frame_end_q   <= 1'b0;
      bit_err_q     <= 1'b0;
      dout_q        <= 1'b0;
      pixel_count_q <= '0;
    end else begin
      shreg         <= shreg_d;
      bit_cnt       <= bit_cnt_d;
      pixel_valid_q <= pv_d;
      frame_end_q   <= fe_d;
      bit_err_q     <= be_d;
      dout_q        <= (state_q == PASS) ? ds : 1'b0;
      if (pv_d) begin
        pixel_data_q  <= word_d;
        pixel_count_q <= pixel_count_q + 8'd1;
      end
    end
  end

  assign bus.pixel_data  = pixel_data_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.bit_err     = bit_err_q;
  assign bus.dout        = dout_q;
  assign bus.pixel_count = pixel_count_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_neopixel_rx.sv
// Randomized bench for neopixel_rx: a pulse-level reference model feeds an
// expected queue that a negedge monitor drains on every pixel_valid.
module tb_neopixel_rx;
  localparam int T_LATCH = 2500;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  neopixel_rx_if bus();
  neopixel_rx dut (.CLOCK_50(clk), .reset(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  // {expected cycle, expected pixel_count, expected word}
  logic [63:0] exp_q[$];

  // reference model: mode 0 = waiting for latch, 1 = capturing, 2 = forwarding
  int          model_mode = 0;
  bit          model_bits[$];
  int          exp_count = 0;
  int          exp_fe = 0, exp_be = 0, got_fe = 0, got_be = 0;
  bit          model_pass = 1'b0, pending_pass = 1'b0;
  logic [23:0] exp_last = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_pulse(input int hi);
    logic [23:0] w;
    if (model_mode != 1) return;
    if (hi < 5 || hi > 60) begin
      exp_be++;
      model_mode = 0;
      model_bits.delete();
    end else begin
      model_bits.push_back(hi > 30);
      if (model_bits.size() == 24) begin
        w = '0;
        foreach (model_bits[i]) w = (w << 1) | 24'(model_bits[i]);
        exp_count = (exp_count + 1) % 256;
        exp_last  = w;
        exp_q.push_back({32'(cyc + 3), 8'(exp_count), w});
        model_mode   = 2;
        pending_pass = 1'b1;
        model_bits.delete();
      end
    end
  endtask

  task automatic model_latch();
    exp_fe++;
    model_mode = 1;
    model_bits.delete();
    model_pass = 1'b0;
  endtask

  task automatic model_reset();
    model_mode   = 0;
    model_bits.delete();
    exp_count    = 0;
    model_pass   = 1'b0;
    pending_pass = 1'b0;
  endtask

  // driver tasks: din always changes 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pulse(input int hi, input int lo);
    bus.din = 1'b1;
    tick(hi);
    bus.din = 1'b0;
    model_pulse(hi);
    tick(4);
    if (pending_pass) begin
      model_pass   = 1'b1;
      pending_pass = 1'b0;
    end
    tick(lo - 4);
  endtask

  function automatic int rand_hi(input bit b);
    return b ? int'($urandom_range(31, 60)) : int'($urandom_range(5, 30));
  endfunction

  task automatic send_word(input logic [23:0] w, input bit fixed);
    for (int i = 23; i >= 0; i--) begin
      if (fixed) send_pulse(w[i] ? 40 : 20, w[i] ? 20 : 40);
      else       send_pulse(rand_hi(w[i]), $urandom_range(20, 30));
    end
  endtask

  task automatic send_rand_bits(input int n);
    for (int i = 0; i < n; i++) send_pulse(rand_hi(1'($urandom_range(0, 1))), $urandom_range(20, 30));
  endtask

  task automatic send_latch();
    bus.din = 1'b0;
    tick(T_LATCH + 10);
    model_latch();
  endtask

  task automatic end_scenario(input string name);
    tick(10);
    check({name, " frame_end count"}, 64'(got_fe), 64'(exp_fe));
    check({name, " bit_err count"},   64'(got_be), 64'(exp_be));
    check({name, " pending pixels"},  64'(exp_q.size()), 64'd0);
  endtask

  // monitor / scoreboard
  logic [2:0]  hist = '0;
  logic [23:0] last_pix = '0;
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst) begin
      hist     = '0;
      last_pix = '0;
    end else begin
      check("one strobe per cycle",
            64'(int'(bus.pixel_valid) + int'(bus.frame_end) + int'(bus.bit_err) > 1), 64'd0);
      check("dout", 64'(bus.dout), 64'(model_pass ? hist[2] : 1'b0));
      if (bus.pixel_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected pixel_valid", 64'(bus.pixel_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("pixel_data",      64'(bus.pixel_data),  64'(e[23:0]));
          check("pixel_count",     64'(bus.pixel_count), 64'(e[31:24]));
          check("pixel_valid cycle", 64'(cyc),           64'(e[63:32]));
        end
      end else begin
        check("pixel_data hold", 64'(bus.pixel_data), 64'(last_pix));
      end
      if (bus.frame_end) got_fe++;
      if (bus.bit_err)   got_be++;
      last_pix = bus.pixel_data;
      hist     = {hist[1:0], bus.din};
    end
  end

  initial begin
    bus.din = 1'b0;
    tick(3);
    check("reset pixel_data",  64'(bus.pixel_data),  64'd0);
    check("reset pixel_valid", 64'(bus.pixel_valid), 64'd0);
    check("reset frame_end",   64'(bus.frame_end),   64'd0);
    check("reset bit_err",     64'(bus.bit_err),     64'd0);
    check("reset dout",        64'(bus.dout),        64'd0);
    check("reset pixel_count", 64'(bus.pixel_count), 64'd0);
    rst = 1'b0;
    tick(2);

    // single pixel with fixed 40/20 and 20/40 timing
    send_latch();
    send_word(24'hFF00AA, 1'b1);
    end_scenario("s1");
    check("s1 pixel_data",  64'(bus.pixel_data),  64'hFF00AA);
    check("s1 pixel_count", 64'(bus.pixel_count), 64'd1);

    // two pixels: second one forwarded on dout
    send_latch();
    send_word(24'h123456, 1'b0);
    send_word(24'hABCDEF, 1'b0);
    send_latch();
    end_scenario("s2");
    check("s2 pixel_data",  64'(bus.pixel_data),  64'h123456);
    check("s2 pixel_count", 64'(bus.pixel_count), 64'd2);

    // threshold: 30 decodes as 0, 31 as 1
    send_pulse(30, 25);
    send_pulse(31, 25);
    send_rand_bits(22);
    end_scenario("s3");
    check("s3 first bits", 64'(bus.pixel_data[23:22]), 64'd1);
    check("s3 pixel_data", 64'(bus.pixel_data), 64'(exp_last));

    // partial word discarded by a latch
    send_latch();
    send_rand_bits(10);
    send_latch();
    send_word(24'h00FF00, 1'b0);
    end_scenario("s4");
    check("s4 pixel_data", 64'(bus.pixel_data), 64'h00FF00);

    // over-long pulse at bit 5, capture only after next latch
    send_latch();
    send_rand_bits(5);
    send_pulse(80, 25);
    send_rand_bits(18);
    check("s5 no capture after error", 64'(bus.pixel_data), 64'h00FF00);
    send_latch();
    send_word(24'($urandom), 1'b0);
    end_scenario("s5");
    check("s5 pixel_data", 64'(bus.pixel_data), 64'(exp_last));

    // legal pulse-width limits, then one step outside each
    send_latch();
    send_pulse(5, 25);
    send_pulse(60, 25);
    send_rand_bits(22);
    check("s6 limit word", 64'(bus.pixel_data[23:22]), 64'd1);
    send_latch();
    send_pulse(4, 25);
    send_latch();
    send_pulse(61, 25);
    send_latch();
    end_scenario("s6");

    // random frames
    for (int f = 0; f < 2; f++) begin
      send_word(24'($urandom), 1'b0);
      if ($urandom_range(0, 1) == 1) send_word(24'($urandom), 1'b0);
      send_latch();
    end
    end_scenario("s7");

    // reset during bit 13
    send_rand_bits(12);
    bus.din = 1'b1;
    tick(10);
    rst = 1'b1;
    bus.din = 1'b0;
    model_reset();
    #2;
    check("async reset pixel_data",  64'(bus.pixel_data),  64'd0);
    check("async reset pixel_count", 64'(bus.pixel_count), 64'd0);
    check("async reset dout",        64'(bus.dout),        64'd0);
    tick(3);
    check("reset pixel_valid", 64'(bus.pixel_valid), 64'd0);
    check("reset frame_end",   64'(bus.frame_end),   64'd0);
    check("reset bit_err",     64'(bus.bit_err),     64'd0);
    rst = 1'b0;
    tick(30);
    send_word(24'($urandom), 1'b0);
    send_latch();
    send_word(24'h0F0F0F, 1'b0);
    end_scenario("s8");
    check("s8 pixel_data",  64'(bus.pixel_data),  64'h0F0F0F);
    check("s8 pixel_count", 64'(bus.pixel_count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
